// File: rtl/sa_pkg.sv
// Shared state encodings and status layout for the autozero sample-acquisition sequencer.
// These values are also decoded by register_set.
package sa_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StPcHi     = 3'd1,
        StSampleHi = 3'd2,
        StPcLo     = 3'd3,
        StSampleLo = 3'd4
    } sa_state_e;

    localparam int unsigned StatusStateLsb = 0;
    localparam int unsigned StatusStateMsb = 2;
    localparam int unsigned StatusPhaseBit = 3;
    localparam int unsigned StatusArmBit   = 4;

    function automatic logic is_hi_phase(input sa_state_e st);
        return (st == StPcHi) || (st == StSampleHi);
    endfunction

    function automatic logic is_pc_state(input sa_state_e st);
        return (st == StPcHi) || (st == StPcLo);
    endfunction

    function automatic logic is_sample_state(input sa_state_e st);
        return (st == StSampleHi) || (st == StSampleLo);
    endfunction

endpackage

// File: rtl/sa_down_counter.sv
// Precharge duration counter: loads a count, steps down to 1 without wrapping,
// and flags done once the count is at or below 1 (so a count of 0 behaves as 1).
module sa_down_counter #(
    parameter int unsigned CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q > CNT_W'(1))) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/sample_acquisition_az.sv
// Autozero sample-acquisition sequencer: precharge, ADC trigger, wait for valid, optional HI/LO
// alternation. Define SA_AZ_SAMPLE_COUNT_EN to add the 32-bit sample_count_o output.
module sample_acquisition_az
    import sa_pkg::*;
#(
    parameter int unsigned CNT_W   = 24,
    parameter int unsigned AZMUX_W = 4,
    parameter int unsigned NPC     = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               arm_i,
    input  logic               p_az_en_i,
    input  logic [CNT_W-1:0]   p_clk_count_precharge_i,
    input  logic [AZMUX_W-1:0] p_azmux_hi_i,
    input  logic [AZMUX_W-1:0] p_azmux_lo_i,
    input  logic [NPC-1:0]     p_pc_sel_i,
    input  logic               adc_valid_i,
    output logic               adc_trig_o,
    output logic [AZMUX_W-1:0] azmux_o,
    output logic [NPC-1:0]     pc_sw_o,
    output logic               sample_done_o,
    output logic               az_phase_o,
    output logic [7:0]         status_o
`ifdef SA_AZ_SAMPLE_COUNT_EN
    ,
    output logic [31:0]        sample_count_o
`endif
);

    sa_state_e          state_q, state_d;
    logic               adc_trig_q, adc_trig_d;
    logic [AZMUX_W-1:0] azmux_q, azmux_d;
    logic [NPC-1:0]     pc_sw_q, pc_sw_d;
    logic               done_q, done_d;
    logic               az_phase_q, az_phase_d;
    logic               az_en_q, az_en_d;
    logic [7:0]         status_q, status_d;
    logic               cnt_load, cnt_en, cnt_done;
    logic               valid_ok, entering;

    sa_down_counter #(
        .CNT_W(CNT_W)
    ) u_pc_counter (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .en_i       (cnt_en),
        .load_val_i (p_clk_count_precharge_i),
        .done_o     (cnt_done)
    );

    always_comb begin
        state_d  = state_q;
        cnt_en   = 1'b0;
        // A valid coinciding with the trigger cycle belongs to no conversion of ours.
        valid_ok = adc_valid_i && !adc_trig_q;
        unique case (state_q)
            StIdle:     if (arm_i) state_d = StPcHi;
            StPcHi: begin
                cnt_en = 1'b1;
                if (cnt_done) state_d = StSampleHi;
            end
            StSampleHi: if (valid_ok) state_d = az_en_q ? StPcLo : StPcHi;
            StPcLo: begin
                cnt_en = 1'b1;
                if (cnt_done) state_d = StSampleLo;
            end
            StSampleLo: if (valid_ok) state_d = StPcHi;
            default:    state_d = StIdle;
        endcase
        if (!arm_i) state_d = StIdle;

        entering   = (state_d != state_q);
        cnt_load   = is_pc_state(state_d) && entering;
        adc_trig_d = is_sample_state(state_d) && entering;
        done_d     = is_sample_state(state_q) && is_pc_state(state_d);
        az_phase_d = done_d ? (state_q == StSampleHi) : az_phase_q;
        az_en_d    = (state_d == StSampleHi && entering) ? p_az_en_i : az_en_q;

        azmux_d = azmux_q;
        pc_sw_d = '0;
        unique case (state_d)
            StIdle:     azmux_d = p_azmux_lo_i;
            StPcHi:     if (entering) azmux_d = p_azmux_hi_i;
            StPcLo:     if (entering) azmux_d = p_azmux_lo_i;
            StSampleHi,
            StSampleLo: pc_sw_d = entering ? p_pc_sel_i : pc_sw_q;
            default:    azmux_d = azmux_q;
        endcase

        status_d = {3'b000, arm_i, is_hi_phase(state_d), state_d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            adc_trig_q <= 1'b0;
            azmux_q    <= '0;
            pc_sw_q    <= '0;
            done_q     <= 1'b0;
            az_phase_q <= 1'b0;
            az_en_q    <= 1'b0;
            status_q   <= '0;
        end else begin
            state_q    <= state_d;
            adc_trig_q <= adc_trig_d;
            azmux_q    <= azmux_d;
            pc_sw_q    <= pc_sw_d;
            done_q     <= done_d;
            az_phase_q <= az_phase_d;
            az_en_q    <= az_en_d;
            status_q   <= status_d;
        end
    end

    assign adc_trig_o    = adc_trig_q;
    assign azmux_o       = azmux_q;
    assign pc_sw_o       = pc_sw_q;
    assign sample_done_o = done_q;
    assign az_phase_o    = az_phase_q;
    assign status_o      = status_q;

`ifdef SA_AZ_SAMPLE_COUNT_EN
    logic [31:0] sample_count_q, sample_count_d;

    always_comb begin
        sample_count_d = sample_count_q;
        if (state_d == StIdle) begin
            sample_count_d = '0;
        end else if (done_d) begin
            sample_count_d = sample_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_count_q <= '0;
        end else begin
            sample_count_q <= sample_count_d;
        end
    end

    assign sample_count_o = sample_count_q;
`endif

endmodule

// File: tb/tb_sample_acquisition_az.sv
// Self-checking bench for sample_acquisition_az: table of acquisition runs plus hand-written
// corner cases; completed-sample phases are checked through an expected-phase queue.
module tb_sample_acquisition_az;

    localparam logic [2:0] S_IDLE = 3'd0, S_PC_HI = 3'd1, S_SMP_HI = 3'd2;
    localparam logic [2:0] S_PC_LO = 3'd3, S_SMP_LO = 3'd4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        arm_i = 1'b0;
    logic        p_az_en_i = 1'b0;
    logic [23:0] p_cnt = 24'd0;
    logic [3:0]  p_hi = 4'h0;
    logic [3:0]  p_lo = 4'hA;
    logic [1:0]  p_sel = 2'b00;
    logic        adc_valid_i = 1'b0;
    logic        adc_trig_o;
    logic [3:0]  azmux_o;
    logic [1:0]  pc_sw_o;
    logic        sample_done_o;
    logic        az_phase_o;
    logic [7:0]  status_o;
`ifdef SA_AZ_SAMPLE_COUNT_EN
    logic [31:0] sample_count_o;
`endif

    int n_tests = 0;
    int n_fail = 0;
    logic exp_q[$];

    sample_acquisition_az dut (
        .clk                     (clk),
        .reset                   (reset),
        .arm_i                   (arm_i),
        .p_az_en_i               (p_az_en_i),
        .p_clk_count_precharge_i (p_cnt),
        .p_azmux_hi_i            (p_hi),
        .p_azmux_lo_i            (p_lo),
        .p_pc_sel_i              (p_sel),
        .adc_valid_i             (adc_valid_i),
        .adc_trig_o              (adc_trig_o),
        .azmux_o                 (azmux_o),
        .pc_sw_o                 (pc_sw_o),
        .sample_done_o           (sample_done_o),
        .az_phase_o              (az_phase_o),
        .status_o                (status_o)
`ifdef SA_AZ_SAMPLE_COUNT_EN
        ,
        .sample_count_o          (sample_count_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cnt;
        bit         az;
        logic [3:0] hi;
        logic [3:0] lo;
        logic [1:0] sel;
        int         nsamp;
        int         wt;
    } vec_t;

    vec_t vecs[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every done pulse must match a phase the stimulus queued up.
    always @(negedge clk) begin
        if (!reset && sample_done_o) begin
            if (exp_q.size() == 0) begin
                chk("spurious_done", {31'd0, sample_done_o}, 32'd0);
            end else begin
                chk("done_phase", {31'd0, az_phase_o}, {31'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic pc_phase(input int len, input logic [3:0] mux, input logic [2:0] st);
        int n = 0;
        while (status_o[2:0] == st && n < 200) begin
            if (n == 0) begin
                chk("pc_azmux", {28'd0, azmux_o}, {28'd0, mux});
                chk("pc_sw", {30'd0, pc_sw_o}, 32'd0);
                chk("pc_trig", {31'd0, adc_trig_o}, 32'd0);
            end
            n++;
            tick();
        end
        chk("pc_len", n, len);
    endtask

    task automatic sample_phase(input logic ph, input logic [3:0] mux, input logic [1:0] sel,
                                input int wt, input bit abort, input logic [3:0] lo);
        logic [2:0] st;
        st = ph ? S_SMP_HI : S_SMP_LO;
        chk("smp_state", {29'd0, status_o[2:0]}, {29'd0, st});
        chk("trig_first", {31'd0, adc_trig_o}, 32'd1);
        chk("smp_sw", {30'd0, pc_sw_o}, {30'd0, sel});
        chk("smp_azmux", {28'd0, azmux_o}, {28'd0, mux});
        chk("status_phase", {31'd0, status_o[3]}, {31'd0, ph});
        tick();
        chk("trig_single", {31'd0, adc_trig_o}, 32'd0);
        chk("smp_hold", {29'd0, status_o[2:0]}, {29'd0, st});
        adc_valid_i = 1'b0;
        repeat (wt) tick();
        chk("smp_wait", {29'd0, status_o[2:0]}, {29'd0, st});
        adc_valid_i = 1'b1;
        if (abort) arm_i = 1'b0;
        else exp_q.push_back(ph);
        tick();
        adc_valid_i = 1'b0;
        if (abort) begin
            chk("abort_state", {29'd0, status_o[2:0]}, {29'd0, S_IDLE});
            chk("abort_done", {31'd0, sample_done_o}, 32'd0);
            chk("abort_sw", {30'd0, pc_sw_o}, 32'd0);
            chk("abort_azmux", {28'd0, azmux_o}, {28'd0, lo});
            chk("abort_trig", {31'd0, adc_trig_o}, 32'd0);
        end
    endtask

    initial begin
        int len;
        logic ph;
        logic [3:0] mux;

        vecs[0] = '{cnt: 5, az: 1'b0, hi: 4'h1, lo: 4'h6, sel: 2'b01, nsamp: 1, wt: 10};
        vecs[1] = '{cnt: 3, az: 1'b1, hi: 4'h1, lo: 4'h2, sel: 2'b10, nsamp: 4, wt: 3};
        vecs[2] = '{cnt: 0, az: 1'b0, hi: 4'h7, lo: 4'h4, sel: 2'b11, nsamp: 2, wt: 1};
        vecs[3] = '{cnt: 1, az: 1'b1, hi: 4'h8, lo: 4'h3, sel: 2'b01, nsamp: 2, wt: 0};

        // Reset state (lo select deliberately nonzero so reset must force azmux to 0)
        tick();
        tick();
        chk("rst_trig", {31'd0, adc_trig_o}, 32'd0);
        chk("rst_done", {31'd0, sample_done_o}, 32'd0);
        chk("rst_phase", {31'd0, az_phase_o}, 32'd0);
        chk("rst_sw", {30'd0, pc_sw_o}, 32'd0);
        chk("rst_azmux", {28'd0, azmux_o}, 32'd0);
        chk("rst_status", {24'd0, status_o}, 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            p_cnt = 24'(vecs[i].cnt);
            p_az_en_i = vecs[i].az;
            p_hi = vecs[i].hi;
            p_lo = vecs[i].lo;
            p_sel = vecs[i].sel;
            arm_i = 1'b0;
            tick();
            tick();
            chk("idle_state", {29'd0, status_o[2:0]}, {29'd0, S_IDLE});
            chk("idle_azmux", {28'd0, azmux_o}, {28'd0, vecs[i].lo});
            chk("idle_sw", {30'd0, pc_sw_o}, 32'd0);
            arm_i = 1'b1;
            tick();
            chk("status_arm", {31'd0, status_o[4]}, 32'd1);
            len = (vecs[i].cnt == 0) ? 1 : vecs[i].cnt;
            ph = 1'b1;
            for (int s = 0; s < vecs[i].nsamp; s++) begin
                ph = vecs[i].az ? (s % 2 == 0) : 1'b1;
                mux = ph ? vecs[i].hi : vecs[i].lo;
                pc_phase(len, mux, ph ? S_PC_HI : S_PC_LO);
                sample_phase(ph, mux, vecs[i].sel, vecs[i].wt, 1'b0, vecs[i].lo);
            end
            arm_i = 1'b0;
            tick();
            chk("end_status", {24'd0, status_o}, 32'd0);
            chk("end_azmux", {28'd0, azmux_o}, {28'd0, vecs[i].lo});
            chk("end_sw", {30'd0, pc_sw_o}, 32'd0);
            chk("last_phase", {31'd0, az_phase_o}, {31'd0, ph});
        end

        // Valid during PC_HI and in the trigger cycle must be ignored
        p_cnt = 24'd4; p_az_en_i = 1'b0; p_hi = 4'h5; p_lo = 4'hC; p_sel = 2'b01;
        arm_i = 1'b1;
        adc_valid_i = 1'b1;
        tick();
        pc_phase(4, 4'h5, S_PC_HI);
        sample_phase(1'b1, 4'h5, 2'b01, 2, 1'b0, 4'hC);
        chk("after_ignore", {29'd0, status_o[2:0]}, {29'd0, S_PC_HI});
        arm_i = 1'b0;
        tick();

        // Abort mid SAMPLE_LO with a simultaneous valid
        p_cnt = 24'd2; p_az_en_i = 1'b1; p_hi = 4'h3; p_lo = 4'h9; p_sel = 2'b11;
        arm_i = 1'b1;
        tick();
        pc_phase(2, 4'h3, S_PC_HI);
        sample_phase(1'b1, 4'h3, 2'b11, 2, 1'b0, 4'h9);
        pc_phase(2, 4'h9, S_PC_LO);
        sample_phase(1'b0, 4'h9, 2'b11, 2, 1'b1, 4'h9);
        tick();
        chk("abort_stays_idle", {29'd0, status_o[2:0]}, {29'd0, S_IDLE});

        // Reset overrides an active run
        arm_i = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("rst_prio_status", {24'd0, status_o}, 32'd0);
        chk("rst_prio_azmux", {28'd0, azmux_o}, 32'd0);
        reset = 1'b0;
        arm_i = 1'b0;
        tick();

`ifdef SA_AZ_SAMPLE_COUNT_EN
        p_cnt = 24'd3; p_az_en_i = 1'b0; p_hi = 4'h1; p_lo = 4'h2; p_sel = 2'b01;
        arm_i = 1'b1;
        tick();
        force dut.sample_count_q = 32'hFFFF_FFFF;
        #1;
        chk("cnt_forced", sample_count_o, 32'hFFFF_FFFF);
        release dut.sample_count_q;
        tick();
        pc_phase(2, 4'h1, S_PC_HI);
        sample_phase(1'b1, 4'h1, 2'b01, 1, 1'b0, 4'h2);
        chk("cnt_wrap", sample_count_o, 32'd0);
        pc_phase(3, 4'h1, S_PC_HI);
        sample_phase(1'b1, 4'h1, 2'b01, 1, 1'b0, 4'h2);
        chk("cnt_incr", sample_count_o, 32'd1);
        reset = 1'b1;
        tick();
        chk("cnt_rst", sample_count_o, 32'd0);
        reset = 1'b0;
        arm_i = 1'b0;
        tick();
`endif

        tick();
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
